// File: rtl/gpio_spi_master.sv
// SPI mode-0 initiator issuing single 16-bit register frames (rw, addr, data)
// to the gpio_expander responder; returns the low byte captured from miso.
module gpio_spi_master #(
    parameter int ADDR_WIDTH  = 7,
    parameter int PDATA_WIDTH = 8,
    parameter int CLK_DIV     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   rw,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [PDATA_WIDTH-1:0] wdata,
    output logic                   busy,
    output logic                   done,
    output logic [PDATA_WIDTH-1:0] rdata,
    output logic                   sclk,
    output logic                   ss,
    output logic                   mosi,
    input  logic                   miso
);

    localparam int FRAME_W = 1 + ADDR_WIDTH + PDATA_WIDTH;
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    state_t               state, state_nxt;
    logic [7:0]           div_cnt, div_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_nxt;
    logic [FRAME_W-1:0]   shift_reg, shift_nxt;
    logic [FRAME_W-1:0]   capture, capture_nxt;
    logic [FRAME_W-1:0]   frame;
    logic                 sclk_nxt, ss_nxt, mosi_nxt, busy_nxt, done_nxt;
    logic [PDATA_WIDTH-1:0] rdata_nxt;
    logic                 div_last;

    assign div_last = (div_cnt == DIV_LAST);
    assign frame    = {rw, addr, rw ? wdata : {PDATA_WIDTH{1'b0}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            capture   <= '0;
            sclk      <= 1'b0;
            ss        <= 1'b1;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            capture   <= capture_nxt;
            sclk      <= sclk_nxt;
            ss        <= ss_nxt;
            mosi      <= mosi_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            rdata     <= rdata_nxt;
        end
    end

    // Every output is the registered copy of a value chosen here, so each
    // phase change lands on sclk/ss/mosi on the same edge as the state change.
    always_comb begin
        state_nxt   = state;
        div_nxt     = div_last ? 8'd0 : div_cnt + 8'd1;
        bit_nxt     = bit_cnt;
        shift_nxt   = shift_reg;
        capture_nxt = capture;
        sclk_nxt    = sclk;
        ss_nxt      = ss;
        mosi_nxt    = mosi;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        rdata_nxt   = rdata;

        case (state)
            IDLE: begin
                div_nxt = '0;
                if (start) begin
                    state_nxt = SETUP;
                    bit_nxt   = '0;
                    shift_nxt = frame;
                    mosi_nxt  = frame[FRAME_W-1];
                    ss_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            SETUP, LOW: begin
                if (div_last) begin
                    state_nxt = HIGH;
                    sclk_nxt  = 1'b1;
                end
            end
            HIGH: begin
                if (div_last) begin
                    sclk_nxt       = 1'b0;
                    capture_nxt    = capture << 1;
                    capture_nxt[0] = miso;
                    bit_nxt        = bit_cnt + 1'b1;
                    // The last falling edge parks mosi low instead of shifting.
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = HOLD;
                        mosi_nxt  = 1'b0;
                    end else begin
                        state_nxt = LOW;
                        shift_nxt = shift_reg << 1;
                        mosi_nxt  = shift_nxt[FRAME_W-1];
                    end
                end
            end
            HOLD: begin
                if (div_last) begin
                    state_nxt = GAP;
                    ss_nxt    = 1'b1;
                    rdata_nxt = capture[PDATA_WIDTH-1:0];
                end
            end
            GAP: begin
                if (div_last) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gpio_spi_master.sv
// Scoreboard bench for gpio_spi_master: one instance at CLK_DIV=2, one at
// CLK_DIV=1; a single negedge monitor collects frames and pops expectations.
module tb_gpio_spi_master;

    typedef struct {
        int          dut;
        logic [15:0] mosi_word;
        logic [7:0]  rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [1:0]  start_v;
    logic [1:0]  busy_v, done_v, sclk_v, ss_v, mosi_v, miso_v;
    logic [7:0]  rdata_a, rdata_b;

    exp_t        exp_q[$];
    logic [15:0] miso_pat[2];
    int          compared   = 0;
    int          mismatched = 0;

    int          rises[2], ss_low[2], busy_cnt[2], gap[2], frames[2];
    logic [15:0] word[2];
    logic [1:0]  prev_sclk, prev_ss;

    always #5 clk = ~clk;

    gpio_spi_master #(.ADDR_WIDTH(7), .PDATA_WIDTH(8), .CLK_DIV(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .rw(rw), .addr(addr),
        .wdata(wdata), .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata_a),
        .sclk(sclk_v[0]), .ss(ss_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0])
    );

    gpio_spi_master #(.ADDR_WIDTH(7), .PDATA_WIDTH(8), .CLK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .rw(rw), .addr(addr),
        .wdata(wdata), .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata_b),
        .sclk(sclk_v[1]), .ss(ss_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1])
    );

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: plays the responder on miso and scores each completed frame.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                rises[g] = 0; ss_low[g] = 0; busy_cnt[g] = 0; gap[g] = 0;
                word[g] = '0; prev_sclk[g] = 1'b0; prev_ss[g] = 1'b1;
                miso_v[g] = 1'b0;
            end else begin
                if (!ss_v[g]) ss_low[g]++; else gap[g]++;
                if (busy_v[g]) busy_cnt[g]++;
                if (prev_ss[g] && !ss_v[g]) begin
                    if (frames[g] > 0) begin
                        compared++;
                        if (gap[g] < 1) begin
                            mismatched++;
                            $display("[TB] FAIL ss_gap dut%0d: got %0d cycles, expected >= 1", g, gap[g]);
                        end
                    end
                    gap[g] = 0;
                end
                if (sclk_v[g] && !prev_sclk[g]) begin
                    word[g] = {word[g][14:0], mosi_v[g]};
                    if (rises[g] < 16) miso_v[g] = miso_pat[g][15 - rises[g]];
                    rises[g]++;
                end
                if (done_v[g]) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_done dut%0d: got done, expected none", g);
                    end else begin
                        automatic exp_t e = exp_q.pop_front();
                        automatic int   cd = (g == 0) ? 2 : 1;
                        automatic logic [7:0] rd = (g == 0) ? rdata_a : rdata_b;
                        check_output("done_dut", g, e.dut);
                        check_output("mosi_word", word[g], e.mosi_word);
                        check_output("sclk_rises", rises[g], 16);
                        check_output("rdata", rd, e.rdata);
                        check_output("ss_low_cycles", ss_low[g], 33 * cd);
                        check_output("busy_cycles", busy_cnt[g], 34 * cd);
                    end
                    frames[g]++;
                    rises[g] = 0; ss_low[g] = 0; busy_cnt[g] = 0; word[g] = '0;
                end
                prev_sclk[g] = sclk_v[g];
                prev_ss[g]   = ss_v[g];
            end
        end
    end

    // One-cycle start pulse; inputs are scrambled after acceptance.
    task automatic apply_stimulus(input int g, input logic r, input logic [6:0] a,
                                  input logic [7:0] d, input logic [15:0] pat,
                                  input logic [15:0] exp_word, input logic [7:0] exp_rd,
                                  input bit push);
        exp_t e;
        @(negedge clk);
        rw = r; addr = a; wdata = d;
        miso_pat[g] = pat;
        start_v[g] = 1'b1;
        if (push) begin
            e.dut = g; e.mosi_word = exp_word; e.rdata = exp_rd;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start_v[g] = 1'b0;
        rw = ~r; addr = ~a; wdata = ~d;
    endtask

    task automatic wait_done(input int g);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done_v[g]) seen = 1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL done_timeout dut%0d: got no done, expected done within 400 cycles", g);
        end
    endtask

    initial begin
        int   seen_rises;
        logic last_sclk;
        reset = 1'b1; start_v = '0; rw = 0; addr = '0; wdata = '0;
        miso_pat[0] = '0; miso_pat[1] = '0;
        frames[0] = 0; frames[1] = 0;
        repeat (3) @(negedge clk);
        check_output("reset_ss", ss_v, 2'b11);
        check_output("reset_sclk", sclk_v, 2'b00);
        check_output("reset_mosi", mosi_v, 2'b00);
        check_output("reset_busy", busy_v, 2'b00);
        check_output("reset_done", done_v, 2'b00);
        check_output("reset_rdata", {rdata_a, rdata_b}, 16'h0000);
        reset = 1'b0;

        apply_stimulus(0, 1'b1, 7'h20, 8'hFF, 16'h1234, 16'hA0FF, 8'h34, 1);
        wait_done(0);
        apply_stimulus(0, 1'b0, 7'h20, 8'h99, 16'h005A, 16'h2000, 8'h5A, 1);
        wait_done(0);
        apply_stimulus(0, 1'b1, 7'h40, 8'hFF, 16'h00C3, 16'hC0FF, 8'hC3, 1);
        wait_done(0);

        // Second start at t0+10 while busy must be ignored.
        apply_stimulus(0, 1'b1, 7'h20, 8'hFF, 16'h0000, 16'hA0FF, 8'h00, 1);
        repeat (9) @(negedge clk);
        rw = 1'b0; addr = 7'h7F; wdata = 8'h00; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0);
        repeat (80) @(negedge clk);

        // Abort a frame after its 5th rising sclk edge.
        apply_stimulus(0, 1'b1, 7'h11, 8'h22, 16'hFFFF, 16'h0, 8'h0, 0);
        seen_rises = 0;
        last_sclk  = sclk_v[0];
        for (int i = 0; i < 100 && seen_rises < 5; i++) begin
            @(negedge clk);
            if (sclk_v[0] && !last_sclk) seen_rises++;
            last_sclk = sclk_v[0];
        end
        check_output("abort_rises_reached", seen_rises, 5);
        reset = 1'b1;
        #1;
        check_output("abort_ss", ss_v[0], 1'b1);
        check_output("abort_sclk", sclk_v[0], 1'b0);
        check_output("abort_mosi", mosi_v[0], 1'b0);
        check_output("abort_busy", busy_v[0], 1'b0);
        check_output("abort_done", done_v[0], 1'b0);
        check_output("abort_rdata", rdata_a, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        apply_stimulus(0, 1'b1, 7'h55, 8'hA5, 16'h0081, 16'hD5A5, 8'h81, 1);
        wait_done(0);

        // CLK_DIV=1 back-to-back writes, start issued the cycle after done.
        apply_stimulus(1, 1'b1, 7'h01, 8'h3C, 16'h00AA, 16'h813C, 8'hAA, 1);
        wait_done(1);
        apply_stimulus(1, 1'b1, 7'h7E, 8'h81, 16'h7755, 16'hFE81, 8'h55, 1);
        wait_done(1);
        repeat (5) @(negedge clk);

        check_output("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
